fft_spectrum_peak: RTL and testbench



---
 rtl/fft_pkg.sv | 18 +
 rtl/spectrum_ram.sv | 27 ++
 rtl/fft_spectrum_peak.sv | 171 +++++++++++++++++
 tb/tb_fft_spectrum_peak.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants and the spectrum-peak FSM state type.
// Used by the FFT controller and by fft_spectrum_peak.
package fft_pkg;

   localparam int DATA_W = 8;
   localparam int EXP_W  = 6;
   localparam int N      = 512;
   localparam int ADDR_W = 9;
   localparam int MAG_W  = 2 * DATA_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FRAME,
      S_FLUSH,
      S_DONE
   } spk_state_t;

endpackage

// File: rtl/spectrum_ram.sv
// Simple dual-port spectrum store, N x MAG_W.
// Synchronous write, registered read. Read-during-write to the same
// address returns the old contents. Written so it maps onto block RAM.
module spectrum_ram
   import fft_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [MAG_W-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [MAG_W-1:0]  rd_data
);

   logic [MAG_W-1:0] mem [N];

   // Write port: one magnitude per cycle from the pipeline
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read port: registered, so data lags the address by one cycle
   always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fft_spectrum_peak.sv
// Squared-magnitude spectrum capture and peak search for one FFT frame.
// Optional build macro FFT_PEAK_SKIP_DC_EN: when defined, bin 0 is left
// out of the peak search (it is still stored in the spectrum RAM).
module fft_spectrum_peak
   import fft_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              source_valid,
   output logic              source_ready,
   input  logic              source_sop,
   input  logic              source_eop,
   input  logic [DATA_W-1:0] source_real,
   input  logic [DATA_W-1:0] source_imag,
   input  logic [EXP_W-1:0]  source_exp,
   input  logic [1:0]        source_error,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [MAG_W-1:0]  rd_data,
   output logic [ADDR_W-1:0] peak_bin,
   output logic [MAG_W-1:0]  peak_mag,
   output logic [EXP_W-1:0]  frame_exp,
   output logic              done,
   output logic              frame_err,
   output logic              busy
);

`ifdef FFT_PEAK_SKIP_DC_EN
   localparam logic [ADDR_W-1:0] FIRST_BIN = ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] FIRST_BIN = '0;
`endif
   localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N - 1);

   spk_state_t state, state_next;

   logic [ADDR_W-1:0]          cnt;
   logic                       flush_cnt;
   logic                       err_flag;
   logic [EXP_W-1:0]           exp_shadow;
   logic                       accept;
   logic                       frame_beat;
   logic                       frame_end;
   logic                       frame_last;
   logic                       beat_bad;
   logic [ADDR_W-1:0]          beat_bin;
   logic signed [2*DATA_W-1:0] re_ext, im_ext, re_sq_c, im_sq_c;
   logic [2*DATA_W-1:0]        s1_re_sq, s1_im_sq;
   logic [ADDR_W-1:0]          s1_bin;
   logic                       s1_valid;
   logic [MAG_W-1:0]           mag_sum;
   logic [ADDR_W-1:0]          pk_bin;
   logic [MAG_W-1:0]           pk_mag;

   assign accept    = source_valid && source_ready;
   assign re_ext    = {{DATA_W{source_real[DATA_W-1]}}, source_real};
   assign im_ext    = {{DATA_W{source_imag[DATA_W-1]}}, source_imag};
   assign re_sq_c   = re_ext * re_ext;
   assign im_sq_c   = im_ext * im_ext;
   assign mag_sum   = {1'b0, s1_re_sq} + {1'b0, s1_im_sq};
   assign frame_err = err_flag;

   // Classify the incoming beat: its bin, whether it closes the frame, and whether it spoils it
   always_comb begin
      beat_bin = cnt;
      if (state == S_IDLE || source_sop) beat_bin = '0;
      frame_last = (beat_bin == LAST_BIN);
      frame_beat = accept && (state == S_FRAME || source_sop);
      frame_end  = frame_beat && (source_eop || frame_last);
      beat_bad   = (source_error != 2'b00) || (source_eop != frame_last) ||
                   (state == S_FRAME && source_sop);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   // FSM next-state and handshake/status outputs; all outputs forced low while in reset
   always_comb begin
      state_next   = state;
      source_ready = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state)
         S_IDLE: begin
            source_ready = rst;
            if (frame_beat) state_next = frame_end ? S_FLUSH : S_FRAME;
         end
         S_FRAME: begin
            source_ready = rst;
            busy         = rst;
            if (frame_end) state_next = S_FLUSH;
         end
         S_FLUSH: begin
            busy = rst;
            if (flush_cnt) state_next = S_DONE;
         end
         S_DONE: begin
            done       = rst;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Bin counter, flush timer, frame exponent shadow and sticky frame error
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt        <= '0;
         flush_cnt  <= 1'b0;
         err_flag   <= 1'b0;
         exp_shadow <= '0;
      end else begin
         flush_cnt <= (state == S_FLUSH) ? ~flush_cnt : 1'b0;
         if (frame_beat) begin
            cnt <= beat_bin + ADDR_W'(1);
            if (source_sop) exp_shadow <= source_exp;
            if (state == S_IDLE) err_flag <= beat_bad;
            else if (beat_bad)   err_flag <= 1'b1;
         end
      end
   end

   // Stage 1: register the two squares together with their bin index
   always_ff @(posedge clk) begin
      s1_valid <= rst && frame_beat;
      s1_re_sq <= re_sq_c;
      s1_im_sq <= im_sq_c;
      s1_bin   <= beat_bin;
   end

   // Stage 2: running peak; the first eligible bin reloads it, later bins need a strictly larger value
   always_ff @(posedge clk) begin
      if (!rst) begin
         pk_bin <= '0;
         pk_mag <= '0;
      end else if (s1_valid) begin
         if (s1_bin == FIRST_BIN) begin
            pk_bin <= s1_bin;
            pk_mag <= mag_sum;
         end else if (s1_bin > FIRST_BIN && mag_sum > pk_mag) begin
            pk_bin <= s1_bin;
            pk_mag <= mag_sum;
         end
      end
   end

   // Publish peak and exponent on the edge entering S_DONE, only for a clean frame
   always_ff @(posedge clk) begin
      if (!rst) begin
         peak_bin  <= '0;
         peak_mag  <= '0;
         frame_exp <= '0;
      end else if (state == S_FLUSH && flush_cnt && !err_flag) begin
         peak_bin  <= pk_bin;
         peak_mag  <= pk_mag;
         frame_exp <= exp_shadow;
      end
   end

   spectrum_ram u_ram (
      .clk     (clk),
      .wr_en   (s1_valid),
      .wr_addr (s1_bin),
      .wr_data (mag_sum),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_fft_spectrum_peak.sv
// Directed self-checking bench for fft_spectrum_peak.
// Expected peak results follow FFT_PEAK_SKIP_DC_EN when it is defined.
module tb_fft_spectrum_peak;

   logic        clk = 1'b0;
   logic        rst;
   logic        source_valid;
   logic        source_ready;
   logic        source_sop;
   logic        source_eop;
   logic [7:0]  source_real;
   logic [7:0]  source_imag;
   logic [5:0]  source_exp;
   logic [1:0]  source_error;
   logic [8:0]  rd_addr;
   logic [16:0] rd_data;
   logic [8:0]  peak_bin;
   logic [16:0] peak_mag;
   logic [5:0]  frame_exp;
   logic        done;
   logic        frame_err;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int done_count = 0;
   int lat;
   int dc0;
   int exp_bin_dc;
   int exp_mag_dc;

   logic [7:0] re_tab [512];
   logic [7:0] im_tab [512];

   localparam logic [5:0] EXP_M3 = 6'b111101;
   localparam logic [5:0] EXP_M7 = 6'b111001;
   localparam logic [5:0] EXP_P5 = 6'd5;
   localparam logic [5:0] EXP_P2 = 6'd2;
   localparam logic [5:0] EXP_P1 = 6'd1;

   fft_spectrum_peak dut (
      .clk          (clk),
      .rst          (rst),
      .source_valid (source_valid),
      .source_ready (source_ready),
      .source_sop   (source_sop),
      .source_eop   (source_eop),
      .source_real  (source_real),
      .source_imag  (source_imag),
      .source_exp   (source_exp),
      .source_error (source_error),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .peak_bin     (peak_bin),
      .peak_mag     (peak_mag),
      .frame_exp    (frame_exp),
      .done         (done),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Count every done pulse, sampled away from the active edge
   always @(negedge clk) begin
      if (done === 1'b1) done_count++;
   end

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic fillPattern(input logic [7:0] bre, input logic [7:0] bim);
      for (int i = 0; i < 512; i++) begin
         re_tab[i] = bre;
         im_tab[i] = bim;
      end
   endtask

   task automatic idleInputs();
      source_valid = 1'b0;
      source_sop   = 1'b0;
      source_eop   = 1'b0;
      source_real  = '0;
      source_imag  = '0;
      source_error = 2'b00;
   endtask

   // Stream nbeats bins from the tables; sop on beat 0, eop on eop_at, error on err_at, optional idle gap after each beat
   task automatic applyStimulus(input int nbeats, input int eop_at, input int err_at,
                                input bit gap, input logic [5:0] fexp);
      int w = 0;
      while (source_ready !== 1'b1 && w < 20) begin
         step();
         w++;
      end
      if (w >= 20) checkOutput("ready_wait", 32'(source_ready), 32'd1);
      for (int i = 0; i < nbeats; i++) begin
         source_valid = 1'b1;
         source_sop   = (i == 0);
         source_eop   = (i == eop_at);
         source_real  = re_tab[i];
         source_imag  = im_tab[i];
         source_exp   = fexp;
         source_error = (i == err_at) ? 2'b01 : 2'b00;
         step();
         if (gap) begin
            idleInputs();
            step();
         end
      end
      idleInputs();
   endtask

   task automatic waitDone(output int n);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checkOutput("done_seen", 32'(done), 32'd1);
   endtask

   task automatic readBin(input int a);
      rd_addr = 9'(a);
      step();
   endtask

   initial begin
`ifdef FFT_PEAK_SKIP_DC_EN
      exp_bin_dc = 3;
      exp_mag_dc = 100;
`else
      exp_bin_dc = 0;
      exp_mag_dc = 16129;
`endif
      rst        = 1'b0;
      source_exp = '0;
      rd_addr    = '0;
      idleInputs();
      repeat (3) step();

      // Reset values
      checkOutput("rst_ready", 32'(source_ready), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_err", 32'(frame_err), 32'd0);
      checkOutput("rst_peak_bin", 32'(peak_bin), 32'd0);
      checkOutput("rst_peak_mag", 32'(peak_mag), 32'd0);
      checkOutput("rst_frame_exp", 32'(frame_exp), 32'd0);
      rst = 1'b1;
      step();
      checkOutput("ready_after_rst", 32'(source_ready), 32'd1);

      // Single tone: bin 37 = (100,-50) -> 12500, others (1,1) -> 2
      fillPattern(8'd1, 8'd1);
      re_tab[37] = 8'd100;
      im_tab[37] = -8'sd50;
      applyStimulus(512, 511, -1, 1'b0, EXP_M3);
      checkOutput("tone_busy", 32'(busy), 32'd1);
      waitDone(lat);
      checkOutput("tone_latency", 32'(lat), 32'd2);
      checkOutput("tone_peak_bin", 32'(peak_bin), 32'd37);
      checkOutput("tone_peak_mag", 32'(peak_mag), 32'd12500);
      checkOutput("tone_frame_exp", 32'(frame_exp), 32'(EXP_M3));
      checkOutput("tone_err", 32'(frame_err), 32'd0);
      step();
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      readBin(37);
      checkOutput("tone_rd37", 32'(rd_data), 32'd12500);
      readBin(5);
      checkOutput("tone_rd5", 32'(rd_data), 32'd2);

      // Tie at the extreme value: lower bin wins
      fillPattern(8'd1, 8'd1);
      re_tab[10]  = 8'h80;
      im_tab[10]  = 8'h80;
      re_tab[200] = 8'h80;
      im_tab[200] = 8'h80;
      applyStimulus(512, 511, -1, 1'b0, EXP_P5);
      waitDone(lat);
      checkOutput("tie_peak_bin", 32'(peak_bin), 32'd10);
      checkOutput("tie_peak_mag", 32'(peak_mag), 32'd32768);
      checkOutput("tie_frame_exp", 32'(frame_exp), 32'(EXP_P5));
      readBin(200);
      checkOutput("tie_rd200", 32'(rd_data), 32'd32768);

      // DC handling: bin 0 = (127,0) -> 16129, bin 3 = (10,0) -> 100
      fillPattern(8'd0, 8'd0);
      re_tab[0] = 8'd127;
      re_tab[3] = 8'd10;
      applyStimulus(512, 511, -1, 1'b0, EXP_P2);
      waitDone(lat);
      checkOutput("dc_peak_bin", 32'(peak_bin), 32'(exp_bin_dc));
      checkOutput("dc_peak_mag", 32'(peak_mag), 32'(exp_mag_dc));
      readBin(0);
      checkOutput("dc_rd0", 32'(rd_data), 32'd16129);

      // Early eop at beat 100: error, previous results held
      fillPattern(8'd1, 8'd1);
      re_tab[50] = 8'd127;
      im_tab[50] = 8'd127;
      applyStimulus(101, 100, -1, 1'b0, EXP_M7);
      waitDone(lat);
      checkOutput("early_latency", 32'(lat), 32'd2);
      checkOutput("early_err", 32'(frame_err), 32'd1);
      checkOutput("early_peak_bin", 32'(peak_bin), 32'(exp_bin_dc));
      checkOutput("early_peak_mag", 32'(peak_mag), 32'(exp_mag_dc));
      checkOutput("early_frame_exp", 32'(frame_exp), 32'(EXP_P2));

      // Next good frame clears the error
      fillPattern(8'd1, 8'd1);
      re_tab[37] = 8'd100;
      im_tab[37] = -8'sd50;
      applyStimulus(512, 511, -1, 1'b0, EXP_M3);
      waitDone(lat);
      checkOutput("recover_err", 32'(frame_err), 32'd0);
      checkOutput("recover_peak_bin", 32'(peak_bin), 32'd37);

      // sop mid-frame at beat 250, then a full frame: one done, error flagged
      step();
      dc0 = done_count;
      fillPattern(8'd1, 8'd1);
      re_tab[100] = 8'd60;
      applyStimulus(250, -1, -1, 1'b0, EXP_P1);
      applyStimulus(512, 511, -1, 1'b0, EXP_P1);
      waitDone(lat);
      checkOutput("midsop_err", 32'(frame_err), 32'd1);
      checkOutput("midsop_peak_bin", 32'(peak_bin), 32'd37);
      repeat (5) step();
      checkOutput("midsop_done_count", 32'(done_count - dc0), 32'd1);

      // source_error on beat 5 spoils an otherwise good frame
      applyStimulus(512, 511, 5, 1'b0, EXP_P1);
      waitDone(lat);
      checkOutput("srcerr_err", 32'(frame_err), 32'd1);
      checkOutput("srcerr_frame_exp", 32'(frame_exp), 32'(EXP_M3));

      // Valid toggling every other cycle: bin 400 = (50,50) -> 5000
      fillPattern(8'd1, 8'd1);
      re_tab[400] = 8'd50;
      im_tab[400] = 8'd50;
      applyStimulus(512, 511, -1, 1'b1, EXP_P5);
      waitDone(lat);
      checkOutput("gap_peak_bin", 32'(peak_bin), 32'd400);
      checkOutput("gap_peak_mag", 32'(peak_mag), 32'd5000);
      checkOutput("gap_err", 32'(frame_err), 32'd0);

      // Reset at beat 300: frame dropped, no done, outputs back to zero
      step();
      dc0 = done_count;
      fillPattern(8'd1, 8'd1);
      applyStimulus(300, -1, -1, 1'b0, EXP_P2);
      checkOutput("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_ready", 32'(source_ready), 32'd0);
      step();
      rst = 1'b1;
      repeat (10) step();
      checkOutput("midrst_no_done", 32'(done_count - dc0), 32'd0);
      checkOutput("midrst_idle_busy", 32'(busy), 32'd0);
      checkOutput("midrst_peak_mag", 32'(peak_mag), 32'd0);

      // Full frame after reset completes normally
      re_tab[37] = 8'd100;
      im_tab[37] = -8'sd50;
      applyStimulus(512, 511, -1, 1'b0, EXP_M3);
      waitDone(lat);
      checkOutput("post_rst_latency", 32'(lat), 32'd2);
      checkOutput("post_rst_peak_bin", 32'(peak_bin), 32'd37);
      checkOutput("post_rst_peak_mag", 32'(peak_mag), 32'd12500);
      checkOutput("post_rst_err", 32'(frame_err), 32'd0);
      checkOutput("post_rst_frame_exp", 32'(frame_exp), 32'(EXP_M3));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
